bus_sequencer: RTL

Control-side counterpart of the general-purpose register file: accepts one register-transfer request at a time and drives the active-low LOAD/ASSERT strobes that the registers obey. It sequences bus settle, load, and release phases so that at most one source drives each bus and a destination is loaded only while its source is stable. It sits between the instruction decoder and the register and ALU strobe inputs.

---
 rtl/bus_seq_pkg.sv | 21 ++
 rtl/bus_seq_onehot_bar.sv | 18 +
 rtl/bus_sequencer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/bus_seq_pkg.sv
// rtl/bus_seq_pkg.sv - states, opcodes and strobe constants shared by bus_sequencer
package bus_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    LOAD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [1:0] OP_MOVE = 2'd0;
  localparam logic [1:0] OP_ALU  = 2'd1;
  localparam logic [1:0] OP_NOP  = 2'd2;

  localparam int MAX_NREG = 8;

  function automatic logic [MAX_NREG-1:0] strobes_off();
    return '1;
  endfunction

endpackage

// File: rtl/bus_seq_onehot_bar.sv
// rtl/bus_seq_onehot_bar.sv - active-low one-hot decode of a register index
module onehot_bar #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic          i_en,
  input  logic [IW-1:0] i_idx,
  output logic [N-1:0]  o_bar
);

  always_comb begin
    o_bar = '1;
    for (int i = 0; i < N; i++) begin
      o_bar[i] = !(i_en && (int'(i_idx) == i));
    end
  end

endmodule

// File: rtl/bus_sequencer.sv
// rtl/bus_sequencer.sv - sequences DRIVE/LOAD/RELEASE strobes for one register transfer at a time
// Strobes are decoded from the next state and registered, so every output comes straight from a flop.
module bus_sequencer
  import bus_seq_pkg::*;
#(
  parameter  int NREG = 4,
  localparam int IW   = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic            CLK,
  input  logic            RST_bar,
  input  logic            REQ,
  input  logic [1:0]      OP,
  input  logic [IW-1:0]   SRC_A,
  input  logic [IW-1:0]   SRC_B,
  input  logic [IW-1:0]   DST,
  output logic            BUSY,
  output logic            ACK,
  output logic [NREG-1:0] LOAD_bar,
  output logic [NREG-1:0] ASSERT_MAIN_bar,
  output logic [NREG-1:0] ASSERT_LHS_bar,
  output logic [NREG-1:0] ASSERT_RHS_bar,
  output logic            ALU_ASSERT_bar
);

  localparam logic [NREG-1:0] OFF   = NREG'(strobes_off());
  localparam int              NSLOT = 1 << IW;
  // Index values that name a real register; the rest of the index space decodes to NOP.
  localparam logic [NSLOT-1:0] VALID = NSLOT'((64'd1 << NREG) - 64'd1);

  state_t        r_state;
  state_t        w_nx_state;
  logic          r_alu;
  logic [IW-1:0] r_src_a;
  logic [IW-1:0] r_src_b;
  logic [IW-1:0] r_dst;

  logic          w_accept;
  logic          w_req_nop;
  logic          w_nx_alu;
  logic [IW-1:0] w_nx_src_a;
  logic [IW-1:0] w_nx_src_b;
  logic [IW-1:0] w_nx_dst;
  logic          w_nx_driving;
  logic [NREG-1:0] w_load_bar;
  logic [NREG-1:0] w_main_bar;
  logic [NREG-1:0] w_lhs_bar;
  logic [NREG-1:0] w_rhs_bar;

  assign w_accept  = REQ && (r_state == IDLE || r_state == RELEASE);
  assign w_req_nop = (OP >= OP_NOP)
                  || !VALID[SRC_A] || !VALID[DST]
                  || (OP == OP_ALU  && !VALID[SRC_B])
                  || (OP == OP_MOVE && SRC_A == DST);

  always_comb begin
    w_nx_state = r_state;
    unique case (r_state)
      IDLE, RELEASE: begin
        if (REQ) w_nx_state = w_req_nop ? RELEASE : DRIVE;
        else     w_nx_state = IDLE;
      end
      DRIVE:   w_nx_state = LOAD;
      LOAD:    w_nx_state = RELEASE;
      default: w_nx_state = IDLE;
    endcase
  end

  // Operands for the coming cycle: fresh inputs on an accept edge, otherwise the captured copy.
  assign w_nx_alu     = w_accept ? (OP == OP_ALU) : r_alu;
  assign w_nx_src_a   = w_accept ? SRC_A : r_src_a;
  assign w_nx_src_b   = w_accept ? SRC_B : r_src_b;
  assign w_nx_dst     = w_accept ? DST   : r_dst;
  assign w_nx_driving = (w_nx_state == DRIVE) || (w_nx_state == LOAD);

  onehot_bar #(.N(NREG), .IW(IW)) u_load (
    .i_en (w_nx_state == LOAD),
    .i_idx(w_nx_dst),
    .o_bar(w_load_bar)
  );

  onehot_bar #(.N(NREG), .IW(IW)) u_main (
    .i_en (w_nx_driving && !w_nx_alu),
    .i_idx(w_nx_src_a),
    .o_bar(w_main_bar)
  );

  onehot_bar #(.N(NREG), .IW(IW)) u_lhs (
    .i_en (w_nx_driving && w_nx_alu),
    .i_idx(w_nx_src_a),
    .o_bar(w_lhs_bar)
  );

  onehot_bar #(.N(NREG), .IW(IW)) u_rhs (
    .i_en (w_nx_driving && w_nx_alu),
    .i_idx(w_nx_src_b),
    .o_bar(w_rhs_bar)
  );

  always_ff @(posedge CLK or negedge RST_bar) begin
    if (!RST_bar) begin
      r_state         <= IDLE;
      r_alu           <= 1'b0;
      r_src_a         <= '0;
      r_src_b         <= '0;
      r_dst           <= '0;
      BUSY            <= 1'b0;
      ACK             <= 1'b0;
      LOAD_bar        <= OFF;
      ASSERT_MAIN_bar <= OFF;
      ASSERT_LHS_bar  <= OFF;
      ASSERT_RHS_bar  <= OFF;
      ALU_ASSERT_bar  <= 1'b1;
    end else begin
      r_state         <= w_nx_state;
      r_alu           <= w_nx_alu;
      r_src_a         <= w_nx_src_a;
      r_src_b         <= w_nx_src_b;
      r_dst           <= w_nx_dst;
      BUSY            <= (w_nx_state != IDLE);
      ACK             <= (w_nx_state == RELEASE);
      LOAD_bar        <= w_load_bar;
      ASSERT_MAIN_bar <= w_main_bar;
      ASSERT_LHS_bar  <= w_lhs_bar;
      ASSERT_RHS_bar  <= w_rhs_bar;
      ALU_ASSERT_bar  <= !(w_nx_driving && w_nx_alu);
    end
  end

endmodule
